// File: rtl/output_buffer_pkg.sv
// Shared definitions for the receive-side output buffer.
//   BYTE_W / WORD_W : widths of received bytes and reassembled words.
//   pair_state_e    : byte-pairing state (LOW = next byte is the low half,
//                     HIGH = low half is pending, next byte completes a word).
package output_buffer_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } pair_state_e;

endpackage

// File: rtl/output_buffer_if.sv
// Byte-in / word-out bus of the output buffer.
//   wrreq, input_data, align : received byte stream and pairing resync.
//   rdreq                    : consumer read request.
//   output_data/valid        : registered read word and its one-cycle strobe.
//   output_ready             : registered "more than READY_LEVEL words" flag.
//   usedw, full, empty       : FIFO fill state.
//   overflow                 : sticky "a completed word was dropped".
// master = producer/consumer side, slave = the buffer itself.
interface output_buffer_if
    import output_buffer_pkg::*;
#(
    parameter int ADDR_W = 6
);
    logic              wrreq;
    logic [BYTE_W-1:0] input_data;
    logic              align;
    logic              rdreq;
    logic [WORD_W-1:0] output_data;
    logic              output_valid;
    logic              output_ready;
    logic [ADDR_W:0]   usedw;
    logic              full;
    logic              empty;
    logic              overflow;

    modport master (
        output wrreq, input_data, align, rdreq,
        input  output_data, output_valid, output_ready,
        input  usedw, full, empty, overflow
    );

    modport slave (
        input  wrreq, input_data, align, rdreq,
        output output_data, output_valid, output_ready,
        output usedw, full, empty, overflow
    );
endinterface

// File: rtl/output_buffer_word_fifo.sv
// Single-clock FIFO with registered read data.
//   clk, arst      : clock, asynchronous active-high reset.
//   push_i/data_i  : write request and word; push_accept_o reports acceptance.
//   pop_i          : read request; q_o updates on the next edge with q_valid_o.
//   usedw_o        : stored word count (0..DEPTH); full_o / empty_o from it.
// A push while full is still accepted when a pop is accepted in the same cycle.
// Memory is not reset.
module word_fifo #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int WIDTH  = 16
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              push_i,
    input  logic [WIDTH-1:0]  push_data_i,
    output logic              push_accept_o,
    input  logic              pop_i,
    output logic [WIDTH-1:0]  q_o,
    output logic              q_valid_o,
    output logic [ADDR_W:0]   usedw_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic [WIDTH-1:0]  q_q;
    logic              q_valid_q;
    logic              pop_ok, push_ok;

    // Acceptance uses the registered count, so a word pushed into an empty
    // FIFO cannot be popped in the same cycle.
    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != FULL_COUNT) || pop_ok);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // When full with push+pop, wr_ptr == rd_ptr; the read below samples the
    // old word before this write lands, so the head is not corrupted.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            q_valid_q <= pop_ok;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                q_q      <= mem[rd_ptr_q];
            end
        end
    end

    assign push_accept_o = push_ok;
    assign q_o           = q_q;
    assign q_valid_o     = q_valid_q;
    assign usedw_o       = count_q;
    assign full_o        = (count_q == FULL_COUNT);
    assign empty_o       = (count_q == '0);

endmodule

// File: rtl/output_buffer.sv
// Receive-side output buffer: pairs received bytes into 16-bit words
// (first byte -> [7:0], second -> [15:8]) and queues them for the consumer.
//   clk, arst : clock, asynchronous active-high reset.
//   bus       : byte input, align, read handshake and status (output_buffer_if).
// Dropped words (FIFO full, no simultaneous pop) set a sticky overflow flag.
module output_buffer
    import output_buffer_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 6,
    parameter int READY_LEVEL = 4
) (
    input  logic                clk,
    input  logic                arst,
    output_buffer_if.slave      bus
);
    localparam logic [ADDR_W:0] READY_COUNT = (ADDR_W + 1)'(READY_LEVEL);

    pair_state_e       state_q, state_d;
    logic [BYTE_W-1:0] low_byte_q, low_byte_d;
    logic              push;
    logic [WORD_W-1:0] push_word;
    logic              push_accept;
    logic              overflow_q, overflow_d;
    logic              ready_q;
    logic [ADDR_W:0]   fifo_usedw;

    // Pairing FSM. align overrides the pairing state: alone it drops any
    // pending low byte; together with wrreq the byte starts a new pair.
    always_comb begin
        state_d    = state_q;
        low_byte_d = low_byte_q;
        push       = 1'b0;
        push_word  = {bus.input_data, low_byte_q};
        if (bus.align) begin
            if (bus.wrreq) begin
                low_byte_d = bus.input_data;
                state_d    = HIGH;
            end else begin
                state_d = LOW;
            end
        end else if (bus.wrreq) begin
            if (state_q == LOW) begin
                low_byte_d = bus.input_data;
                state_d    = HIGH;
            end else begin
                push    = 1'b1;
                state_d = LOW;
            end
        end
    end

    // A completed word the FIFO refuses is lost; the FSM still returns to LOW.
    assign overflow_d = overflow_q || (push && !push_accept);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= LOW;
            low_byte_q <= '0;
            overflow_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            low_byte_q <= low_byte_d;
            overflow_q <= overflow_d;
            ready_q    <= (fifo_usedw > READY_COUNT);
        end
    end

    word_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (WORD_W)
    ) u_fifo (
        .clk           (clk),
        .arst          (arst),
        .push_i        (push),
        .push_data_i   (push_word),
        .push_accept_o (push_accept),
        .pop_i         (bus.rdreq),
        .q_o           (bus.output_data),
        .q_valid_o     (bus.output_valid),
        .usedw_o       (fifo_usedw),
        .full_o        (bus.full),
        .empty_o       (bus.empty)
    );

    assign bus.usedw        = fifo_usedw;
    assign bus.output_ready = ready_q;
    assign bus.overflow     = overflow_q;

endmodule

// File: doc/output_buffer.md
Name: output_buffer

Overview:
Receive-side counterpart of the transmitter input buffer.
- Accepts the byte stream recovered by the receiver.
- Pairs bytes back into 16-bit words: first byte goes to [7:0], second to [15:8], the same order in which the transmitter serialises them.
- Stores the words in a single-clock FIFO and presents them to the downstream consumer with a read request/valid handshake and a threshold "ready" flag.

Parameters:
- DEPTH, 64, FIFO depth in 16-bit words; power of two, minimum 4.
- ADDR_W, 6, log2(DEPTH); pointer width.
- READY_LEVEL, 4, output_ready asserts when stored word count > READY_LEVEL; must be < DEPTH.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- arst  input  1  reset, asynchronous, active-high.
- wrreq  input  1  input_data carries a valid received byte this cycle.
- input_data  input  8  received byte.
- align  input  1  resynchronise byte pairing; discards any pending low byte.
- rdreq  input  1  consumer requests one word.
- output_data  output  16  word read from FIFO, registered.
- output_valid  output  1  one-cycle pulse; output_data is valid.
- output_ready  output  1  registered; word count > READY_LEVEL.
- usedw  output  ADDR_W+1  number of words stored, 0..DEPTH.
- full  output  1  usedw == DEPTH.
- empty  output  1  usedw == 0.
- overflow  output  1  sticky; a completed word was dropped.

Behaviour:
Reset (arst high, asynchronous):
- Pairing state = LOW.
- Pointers, usedw, output_data, output_valid, output_ready and overflow all 0.
- full = 0, empty = 1.
- Memory contents are not reset.
- Reset mid-word discards the pending low byte.
- Reset release needs no special handling beyond synchronous operation from the next edge.

Pairing FSM, states LOW and HIGH:
- LOW & wrreq: latch input_data into low_byte; go to HIGH.
- HIGH & wrreq: form word {input_data, low_byte}; issue push; go to LOW.
- No wrreq: hold state.
- align has priority over the pairing state. align & !wrreq: go to LOW; pending byte dropped.
- align & wrreq in the same cycle: the byte is treated as a first (low) byte regardless of state; go to HIGH.

FIFO push:
- A push is accepted if !full, or if full with an accepted pop in the same cycle.
- Otherwise the word is dropped and overflow is set; it stays set until reset.
- The pairing FSM still returns to LOW when a word is dropped.

FIFO pop:
- rdreq & !empty: the head word appears on output_data at the next edge with output_valid = 1 for exactly that cycle. Read latency is 1 cycle.
- rdreq & empty: ignored; output_valid = 0; output_data holds its last value.
- Data written in cycle N is poppable from cycle N+1. A push into an empty FIFO with rdreq in the same cycle is not returned that cycle.

Counting and pointers:
- Simultaneous accepted push and pop: usedw unchanged.
- Pointers are ADDR_W bits and wrap DEPTH-1 -> 0.
- usedw, full and empty come from the registered count, not from pointer compare.

output_ready:
- Registered each clock from the current usedw: output_ready <= (usedw > READY_LEVEL).
- It lags usedw by one cycle.

Decomposition:
- Shared package holds constants BYTE_W = 8 and WORD_W = 16, and the pairing-state enum {LOW, HIGH}.
- One natural sub-module: word_fifo, a single-clock, parameterised DEPTH/width FIFO providing push/pop/usedw/full/empty, registered q and a same-cycle push+pop rule.
- Pairing FSM, overflow flag and output_ready stay in output_buffer.

Test Plan:
1. Reset, then bytes 0x34, 0x12, 0x78, 0x56 on consecutive cycles -> usedw = 2. Two rdreq cycles -> output_data 0x1234 then 0x5678, each with a single output_valid pulse one cycle after its rdreq.
2. Bytes 0xAA, then align, then 0x01, 0x02 -> one word 0x0201 stored; 0xAA discarded. Repeat with align asserted in the same cycle as 0x01 -> same result.
3. Write 2*DEPTH bytes (128 with DEPTH=64), then 2 more -> full = 1, overflow = 1, usedw = 64. Read all 64 -> the first 64 words in order, then empty = 1.
4. With full = 1, push and rdreq in the same cycle -> usedw stays 64, overflow stays 0, and the new word is read last.
5. Fill to 5 words (READY_LEVEL = 4) -> output_ready rises one cycle after usedw reaches 5. One read drops usedw to 4 -> output_ready falls one cycle after that.
6. Assert arst asynchronously while HIGH with 3 words stored -> all outputs clear immediately, empty = 1. Next byte pair after release forms a word with the first post-reset byte as the low byte.
